// File: rtl/hd_program_loader.sv
// Copies len words from one HardDisk track into InstructionMemory, one word per cycle.
// Reads are issued in COPY; each write trails its read by one cycle, and DRAIN retires the last one.
module hd_program_loader #(
    parameter int DATA_W      = 32,
    parameter int TRK_W       = 4,
    parameter int TRACK_WORDS = 256,
    parameter int HD_AW       = 12,
    parameter int IM_AW       = 8,
    parameter int LEN_W       = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [TRK_W-1:0]  trilha,
    input  logic [IM_AW-1:0]  dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic [HD_AW-1:0]  hd_addr,
    input  logic [DATA_W-1:0] hd_q,
    output logic [IM_AW-1:0]  im_waddr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              im_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int OFF_W = $clog2(TRACK_WORDS);
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(TRACK_WORDS);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [HD_AW-1:0]   hd_addr_q;
    logic [IM_AW-1:0]   im_waddr_q;
    logic [IM_AW-1:0]   dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               im_we_q;
    logic               err_q;
    logic               req_ok;
    logic               last_read;

    assign req_ok    = (len != '0) && ({1'b0, len} <= MAX_LEN);
    assign last_read = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && req_ok) state_d = COPY;
            COPY:    if (last_read)       state_d = DRAIN;
            DRAIN:                        state_d = DONE;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            hd_addr_q  <= '0;
            im_waddr_q <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            im_we_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // A write is due in the cycle after every COPY cycle, including the last read.
            im_we_q <= (state_q == COPY);
            err_q   <= (state_q == IDLE) && start && !req_ok;
            case (state_q)
                IDLE: begin
                    if (start && req_ok) begin
                        hd_addr_q <= HD_AW'({trilha, {OFF_W{1'b0}}});
                        dst_q     <= dst_base;
                        len_q     <= len;
                        cnt_q     <= '0;
                    end
                end
                COPY: begin
                    im_waddr_q <= dst_q + IM_AW'(cnt_q);
                    cnt_q      <= cnt_q + LEN_W'(1);
                    // Hold the final read address so hd_addr stays put outside COPY.
                    if (!last_read) hd_addr_q <= hd_addr_q + HD_AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign hd_addr  = hd_addr_q;
    assign im_waddr = im_waddr_q;
    assign im_wdata = hd_q;
    assign im_we    = im_we_q;
    assign busy     = (state_q == COPY) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Bench for hd_program_loader: HardDisk/IM models, a per-cycle behavioural reference,
// directed scenarios with literal expectations and a randomized run.
module tb_hd_program_loader;

    localparam int DATA_W = 32;
    localparam int TRK_W  = 4;
    localparam int TW     = 256;
    localparam int HD_AW  = 12;
    localparam int IM_AW  = 8;
    localparam int LEN_W  = 9;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [TRK_W-1:0]  trilha;
    logic [IM_AW-1:0]  dst_base;
    logic [LEN_W-1:0]  len;
    logic [HD_AW-1:0]  hd_addr;
    logic [DATA_W-1:0] hd_q;
    logic [IM_AW-1:0]  im_waddr;
    logic [DATA_W-1:0] im_wdata;
    logic              im_we, busy, done, err;

    logic [DATA_W-1:0] hd_mem [0:(1<<HD_AW)-1];
    logic [DATA_W-1:0] im_mem [0:(1<<IM_AW)-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state: one outstanding transfer, described by its relative cycle
    bit m_active = 1'b0;
    bit m_err    = 1'b0;
    bit m_rst    = 1'b0;
    bit chk_en   = 1'b0;
    int m_rel, m_len, m_trk, m_dst;
    int last_hd  = 0;

    int busy_cnt, done_cnt, wr_cnt, err_cnt, done_at, start_cyc;

    always #5 clock = ~clock;

    hd_program_loader #(
        .DATA_W(DATA_W), .TRK_W(TRK_W), .TRACK_WORDS(TW),
        .HD_AW(HD_AW), .IM_AW(IM_AW), .LEN_W(LEN_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .trilha(trilha),
        .dst_base(dst_base), .len(len), .hd_addr(hd_addr), .hd_q(hd_q),
        .im_waddr(im_waddr), .im_wdata(im_wdata), .im_we(im_we),
        .busy(busy), .done(done), .err(err)
    );

    always @(posedge clock) hd_q <= hd_mem[hd_addr];
    always @(posedge clock) if (im_we === 1'b1) im_mem[im_waddr] <= im_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) begin : model
        bit was_idle;
        cyc++;
        if (reset === 1'b1) begin
            m_active = 1'b0;
            m_err    = 1'b0;
            m_rst    = 1'b1;
            last_hd  = 0;
            chk_en   = 1'b1;
        end else begin
            m_rst    = 1'b0;
            m_err    = 1'b0;
            was_idle = !m_active;
            if (m_active) begin
                m_rel++;
                if (m_rel > m_len + 1) m_active = 1'b0;
            end
            if (was_idle && start === 1'b1) begin
                if (int'(len) >= 1 && int'(len) <= TW) begin
                    m_active = 1'b1;
                    m_rel    = 0;
                    m_len    = int'(len);
                    m_trk    = int'(trilha);
                    m_dst    = int'(dst_base);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_active && m_rel < m_len) last_hd = m_trk * TW + m_rel;
        end
    end

    always @(negedge clock) begin : compare
        bit e_busy, e_done, e_we;
        if (chk_en) begin
            e_busy = m_active && (m_rel <= m_len);
            e_done = m_active && (m_rel == m_len + 1);
            e_we   = m_active && (m_rel >= 1) && (m_rel <= m_len);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(m_err));
            chk("im_we", 64'(im_we), 64'(e_we));
            chk("hd_addr", 64'(hd_addr), 64'(last_hd));
            if (e_we) begin
                chk("im_waddr", 64'(im_waddr), 64'((m_dst + m_rel - 1) % (1 << IM_AW)));
                chk("im_wdata", 64'(im_wdata), 64'(hd_mem[m_trk * TW + m_rel - 1]));
            end
            if (m_rst) chk("im_waddr_rst", 64'(im_waddr), 64'(0));
            if (busy === 1'b1) busy_cnt++;
            if (im_we === 1'b1) wr_cnt++;
            if (err === 1'b1) err_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
        end
    end

    task automatic clr();
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; err_cnt = 0; done_at = -1;
    endtask

    // called 1 time unit after a rising edge; leaves inputs idle after the sampling edge
    task automatic req(input int t, input int d, input int l);
        start     = 1'b1;
        trilha    = TRK_W'(t);
        dst_base  = IM_AW'(d);
        len       = LEN_W'(l);
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; trilha = '0; dst_base = '0; len = '0;
        for (int a = 0; a < (1 << HD_AW); a++)
            hd_mem[a] = ((a >> 8) == 2) ? 32'hD000_0000 + 32'(a * 3) : $urandom;
        for (int a = 0; a < (1 << IM_AW); a++) im_mem[a] = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // track 2 -> IM 0x10, four words
        clr(); req(2, 'h10, 4);
        repeat (8) @(posedge clock); #1;
        chk("A_im10", 64'(im_mem[8'h10]), 64'h D000_0600);
        chk("A_im11", 64'(im_mem[8'h11]), 64'h D000_0603);
        chk("A_im12", 64'(im_mem[8'h12]), 64'h D000_0606);
        chk("A_im13", 64'(im_mem[8'h13]), 64'h D000_0609);
        chk("A_writes", 64'(wr_cnt), 64'd4);
        chk("A_busy_cycles", 64'(busy_cnt), 64'd5);
        chk("A_done_count", 64'(done_cnt), 64'd1);
        chk("A_done_cycle", 64'(done_at - start_cyc), 64'd6);
        $display("scenario A: trk 2 dst 10 len 4, writes %0d busy %0d", wr_cnt, busy_cnt);

        // rejected lengths
        clr(); req(1, 0, 0);
        repeat (3) @(posedge clock); #1;
        req(1, 0, 257);
        repeat (3) @(posedge clock); #1;
        chk("B_err_pulses", 64'(err_cnt), 64'd2);
        chk("B_writes", 64'(wr_cnt), 64'd0);
        chk("B_busy", 64'(busy_cnt), 64'd0);
        $display("scenario B: len 0 and 257, err pulses %0d", err_cnt);

        // destination wraps past the top of IM
        clr(); req(2, 'hFE, 4);
        repeat (8) @(posedge clock); #1;
        chk("C_imFE", 64'(im_mem[8'hFE]), 64'h D000_0600);
        chk("C_imFF", 64'(im_mem[8'hFF]), 64'h D000_0603);
        chk("C_im00", 64'(im_mem[8'h00]), 64'h D000_0606);
        chk("C_im01", 64'(im_mem[8'h01]), 64'h D000_0609);
        chk("C_done", 64'(done_cnt), 64'd1);
        chk("C_err", 64'(err_cnt), 64'd0);
        $display("scenario C: dst FE wrap, writes %0d", wr_cnt);

        // reset during cycle 4 of an 8-word copy
        clr(); req(3, 'h20, 8);
        repeat (3) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock); #1;
        chk("D_writes", 64'(wr_cnt), 64'd3);
        chk("D_done", 64'(done_cnt), 64'd0);
        $display("scenario D: reset mid-copy, writes %0d", wr_cnt);

        // start re-pulsed with new fields mid-copy
        clr(); req(5, 'h40, 16);
        repeat (4) @(posedge clock); #1;
        start = 1'b1; trilha = 4'd7; len = 9'd3; dst_base = 8'h90;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock); #1;
        chk("E_writes", 64'(wr_cnt), 64'd16);
        chk("E_done", 64'(done_cnt), 64'd1);
        chk("E_err", 64'(err_cnt), 64'd0);
        chk("E_last_word", 64'(im_mem[8'h4F]), 64'(hd_mem[5 * TW + 15]));
        $display("scenario E: restart ignored, writes %0d done %0d", wr_cnt, done_cnt);

        // randomized traffic, checked cycle by cycle against the model
        clr();
        for (int i = 0; i < 1500; i++) begin
            int s;
            @(posedge clock); #1;
            start    = ($urandom_range(0, 99) < 12);
            trilha   = TRK_W'($urandom);
            dst_base = IM_AW'($urandom);
            s = int'($urandom_range(0, 19));
            if (s == 0)      len = '0;
            else if (s == 1) len = LEN_W'($urandom_range(257, 511));
            else if (s == 2) len = LEN_W'(256);
            else             len = LEN_W'($urandom_range(1, 24));
            reset = ($urandom_range(0, 199) == 0);
        end
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        repeat (300) @(posedge clock); #1;
        $display("random run: writes %0d done %0d err %0d", wr_cnt, done_cnt, err_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hd_program_loader.md
HD_PROGRAM_LOADER -- requirements
Module: hd_program_loader

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, word width of HardDisk and InstructionMemory.
REQ-002 SHALL provide parameter TRK_W, default 4, track (trilha) number width.
REQ-003 SHALL provide parameter TRACK_WORDS, default 256, words per track (power of two).
REQ-004 SHALL provide parameter HD_AW, default 12, HardDisk word-address width (= TRK_W + log2(TRACK_WORDS)).
REQ-005 SHALL provide parameter IM_AW, default 8, InstructionMemory address width.
REQ-006 SHALL provide parameter LEN_W, default 9, copy-length width.
REQ-007 clock  in  1  single system clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  copy request, sampled on rising edge while idle.
REQ-010 trilha  in  TRK_W  source track number.
REQ-011 dst_base  in  IM_AW  first InstructionMemory destination address.
REQ-012 len  in  LEN_W  number of words to copy.
REQ-013 hd_addr  out  HD_AW  HardDisk read address.
REQ-014 hd_q  in  DATA_W  HardDisk read data, valid exactly 1 cycle after hd_addr.
REQ-015 im_waddr  out  IM_AW  InstructionMemory write address.
REQ-016 im_wdata  out  DATA_W  InstructionMemory write data.
REQ-017 im_we  out  1  InstructionMemory write enable (flagWrite).
REQ-018 busy  out  1  copy in progress.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err  out  1  one-cycle rejected-request pulse.

Function
REQ-021 SHALL implement FSM states IDLE, COPY, DRAIN, DONE.
REQ-022 IDLE: start=1 with 1 <= len <= TRACK_WORDS -> latch trilha, dst_base, len; go COPY next cycle.
REQ-023 IDLE: start=1 with len=0 or len>TRACK_WORDS -> err=1 next cycle, no writes, stay IDLE.
REQ-024 COPY: in cycle k (k=0..len-1) hd_addr SHALL equal trilha*TRACK_WORDS + k.
REQ-025 Cycle after each issued read: im_we=1, im_waddr=(dst_base+k) mod 2^IM_AW, im_wdata=hd_q.
REQ-026 Throughput SHALL be one word per cycle, no bubbles.
REQ-027 After issuing read len-1, COPY -> DRAIN; DRAIN performs final write, then -> DONE.
REQ-028 DONE: done=1 for exactly one cycle, busy=0, im_we=0; next state IDLE.
REQ-029 busy=1 in COPY and DRAIN only; total busy cycles = len+1; done at cycle len+2 after start sample.
REQ-030 start while busy or in DONE SHALL be ignored, no err.
REQ-031 Input changes on trilha/dst_base/len during copy SHALL not affect the transfer.
REQ-032 Destination address SHALL wrap modulo 2^IM_AW without error; source never crosses track boundary.
REQ-033 im_we SHALL be 0 in IDLE and DONE; exactly len write pulses per accepted request.
REQ-034 hd_addr SHALL hold its last value when not in COPY.

Reset
REQ-035 reset=1 at any edge SHALL force IDLE; next cycle im_we=0, busy=0, done=0, err=0, hd_addr=0, im_waddr=0.
REQ-036 reset mid-copy SHALL abort with no further writes; partial writes already made are not undone.
REQ-037 reset SHALL take priority over start in the same cycle.

Verification
REQ-038 trilha=2, dst_base=0x10, len=4, HD preloaded -> hd_addr 0x200..0x203; IM 0x10..0x13 written, busy 5 cycles, done at cycle 6.
REQ-039 len=0, then len=257 -> err pulse each, im_we never asserted, busy stays 0.
REQ-040 dst_base=0xFE, len=4 -> writes to 0xFE,0xFF,0x00,0x01, done pulse, no err.
REQ-041 len=8, reset asserted at cycle 4 -> exactly 3 writes observed, busy=0 next cycle, no done.
REQ-042 start re-pulsed and trilha changed mid-copy (len=16) -> ignored; 16 writes from original track; done once.
